// File: rtl/mem_initiator.sv
// mem_initiator: initiator side of a req/gnt/rvalid memory port.
// Accepts single-word commands from a valid/ready core interface and issues them as requests.
// A request is held stable until granted. Responses are returned in issue order, and a tag FIFO
// remembers whether each outstanding access was a read or a write.
module mem_initiator #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          BYTE_ADDR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // core-side command interface
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_we_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  // core-side response interface (no backpressure)
  output logic                  rsp_valid_o,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  // memory port
  output logic                  port_req_o,
  input  logic                  port_gnt_i,
  output logic [ADDR_WIDTH-1:0] port_addr_o,
  output logic                  port_we_o,
  output logic [DATA_WIDTH-1:0] port_wdata_o,
  input  logic                  port_rvalid_i,
  input  logic [DATA_WIDTH-1:0] port_rdata_i,
  // sticky protocol error
  output logic                  err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // request register and FSM state
  state_e                state_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // outstanding-access tracking
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;

  // response and error registers
  logic                  rsp_valid_q;
  logic                  rsp_we_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  err_q;

  // handshake decode
  logic                  granted;
  logic                  pop;
  logic                  spurious;
  logic                  pop_we;
  logic                  cmd_ready;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] cmd_port_addr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Decode grants, responses and the command-side ready condition.
  always_comb begin
    granted  = (state_q == StReq) & port_gnt_i;
    pop      = port_rvalid_i & (cnt_q != '0);
    spurious = port_rvalid_i & (cnt_q == '0);
    pop_we   = tag_q[rd_ptr_q];
    // A response in the same cycle frees a slot, so it counts toward room.
    if (state_q == StIdle) begin
      cmd_ready = (cnt_q < MaxCnt) | pop;
    end else begin
      cmd_ready = granted & (((cnt_q + 1'b1) < MaxCnt) | pop);
    end
    accept        = cmd_valid_i & cmd_ready;
    cmd_port_addr = BYTE_ADDR ? (cmd_addr_i >> 2) : cmd_addr_i;
  end

  // Outstanding count: a grant adds one, a valid response removes one, both cancel.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({granted, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Request FSM: IDLE loads a command, REQ holds it until granted, reloading on back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            addr_q  <= cmd_port_addr;
            we_q    <= cmd_we_i;
            wdata_q <= cmd_wdata_i;
          end
        end
        StReq: begin
          if (granted) begin
            if (accept) begin
              addr_q  <= cmd_port_addr;
              we_q    <= cmd_we_i;
              wdata_q <= cmd_wdata_i;
            end else begin
              state_q <= StIdle;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Tag FIFO and outstanding counter; push on grant, pop on a non-spurious response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (granted) begin
        tag_q[wr_ptr_q] <= we_q;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Registered response: one cycle after rvalid; writes return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= pop;
      rsp_we_q    <= pop & pop_we;
      rsp_rdata_q <= (pop && !pop_we) ? port_rdata_i : '0;
    end
  end

  // Sticky error on a response that has no matching outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (spurious) begin
      err_q <= 1'b1;
    end
  end

  assign cmd_ready_o  = cmd_ready;
  assign port_req_o   = req_q;
  assign port_addr_o  = addr_q;
  assign port_we_o    = we_q;
  assign port_wdata_o = wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_we_o     = rsp_we_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: behavioural memory responder plus an in-order response scoreboard.
module tb_mem_initiator;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 2;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic          cmd_we_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_we_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          port_req_o;
  logic          port_gnt_i;
  logic [AW-1:0] port_addr_o;
  logic          port_we_o;
  logic [DW-1:0] port_wdata_o;
  logic          port_rvalid_i;
  logic [DW-1:0] port_rdata_i;
  logic          err_o;

  mem_initiator #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO),
    .BYTE_ADDR       (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_we_i      (cmd_we_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_we_o      (rsp_we_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .port_req_o    (port_req_o),
    .port_gnt_i    (port_gnt_i),
    .port_addr_o   (port_addr_o),
    .port_we_o     (port_we_o),
    .port_wdata_o  (port_wdata_o),
    .port_rvalid_i (port_rvalid_i),
    .port_rdata_i  (port_rdata_i),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  int   total;
  int   bad;
  int   cyc;
  int   rsp_count;
  int   rvalid_cyc;
  exp_t exp_q[$];
  int   gnt_cyc_q[$];
  int   rsp_cyc_q[$];

  // memory responder controls
  bit            gnt_en;
  bit            rsp_hold;
  int            credits;
  int            spur;
  logic [DW-1:0] mem [256];
  bit            mem_wr [256];
  logic [DW-1:0] rsp_pipe[$];

  // Contents of never-written words; word 4 (byte address 0x10) holds 0xDEADBEEF.
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return 32'hDEADBEEF + {24'h0, a} - 32'd4;
  endfunction

  // Memory: grants per gnt_en, answers each grant one cycle later unless held back.
  task automatic mem_model();
    bit            fire;
    bit            f_we;
    logic [7:0]    f_a;
    logic [DW-1:0] f_wd;
    forever begin
      @(posedge clk);
      cyc++;
      fire = rst_n && port_req_o && port_gnt_i;
      f_we = port_we_o;
      f_a  = port_addr_o[7:0];
      f_wd = port_wdata_o;
      #1;
      if (fire) begin
        gnt_cyc_q.push_back(cyc);
        if (f_we) begin
          mem[f_a]    = f_wd;
          mem_wr[f_a] = 1'b1;
          rsp_pipe.push_back('0);
        end else begin
          rsp_pipe.push_back(mem_wr[f_a] ? mem[f_a] : init_val(f_a));
        end
      end
      port_gnt_i = gnt_en;
      if (spur > 0) begin
        spur--;
        port_rvalid_i = 1'b1;
        port_rdata_i  = 32'hBAD0BAD0;
      end else if (rst_n && rsp_pipe.size() > 0 && (!rsp_hold || credits > 0)) begin
        if (rsp_hold) credits--;
        port_rvalid_i = 1'b1;
        port_rdata_i  = rsp_pipe.pop_front();
      end else begin
        port_rvalid_i = 1'b0;
        port_rdata_i  = '0;
      end
    end
  endtask

  // Scoreboard: every response is popped against the expectation queued at issue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (port_rvalid_i) rvalid_cyc = cyc;
      if (rsp_valid_o) begin
        rsp_count++;
        rsp_cyc_q.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: got rsp we=%0b rdata=%h, required no response",
                   rsp_we_o, rsp_rdata_o);
        end else begin
          e = exp_q.pop_front();
          if (rsp_we_o !== e.we || rsp_rdata_o !== e.data) begin
            bad++;
            $display("FAIL rsp_data: got we=%0b rdata=%h, required we=%0b rdata=%h",
                     rsp_we_o, rsp_rdata_o, e.we, e.data);
          end
        end
      end
    end
  endtask

  // Present a command and return just after the accepting clock edge (valid left high).
  task automatic send_cmd(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_we_i    = we;
    cmd_wdata_i = wd;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (ok) begin
      @(posedge clk);
    end else begin
      bad++;
      $display("FAIL cmd_accept: addr=%h ready stayed 0 for 50 cycles, required acceptance", addr);
    end
  endtask

  // Wait (bounded) until the response count reaches target and the scoreboard is empty.
  task automatic wait_rsp(input int target, input string name);
    for (int i = 0; i < 100 && rsp_count < target; i++) @(posedge clk);
    total++;
    if (rsp_count < target || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_rsp_count: got %0d responses (%0d pending), required %0d",
               name, rsp_count, exp_q.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({port_req_o, port_we_o, rsp_valid_o, rsp_we_o, err_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got req/we/rsp_valid/rsp_we/err=%b, required 00000",
               {port_req_o, port_we_o, rsp_valid_o, rsp_we_o, err_o});
    end
    total++;
    if (port_addr_o !== '0 || port_wdata_o !== '0 || rsp_rdata_o !== '0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required all 0",
               port_addr_o, port_wdata_o, rsp_rdata_o);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got cmd_ready_o=%b, required 1", cmd_ready_o);
    end
  endtask

  task automatic test_read();
    int base;
    base = rsp_count;
    send_cmd(32'h10, 1'b0, '0);
    exp_q.push_back('{we: 1'b0, data: 32'hDEADBEEF});
    @(negedge clk);
    cmd_valid_i = 1'b0;
    total++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h4 || port_we_o !== 1'b0) begin
      bad++;
      $display("FAIL read_req: got req=%b addr=%h we=%b, required req=1 addr=00000004 we=0",
               port_req_o, port_addr_o, port_we_o);
    end
    wait_rsp(base + 1, "read");
    total++;
    if (rsp_cyc_q.size() == 0 || rsp_cyc_q[rsp_cyc_q.size()-1] != rvalid_cyc + 1) begin
      bad++;
      $display("FAIL read_latency: got rsp %0d cycles after rvalid, required 1",
               (rsp_cyc_q.size() == 0) ? -1 : rsp_cyc_q[rsp_cyc_q.size()-1] - rvalid_cyc);
    end
  endtask

  task automatic test_stall();
    int base;
    base   = rsp_count;
    gnt_en = 1'b0;
    send_cmd(32'h20, 1'b1, 32'hA5A50001);
    exp_q.push_back('{we: 1'b1, data: 32'h0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmd_valid_i = 1'b0;
      #1;
      total++;
      if (port_req_o !== 1'b1 || port_addr_o !== 32'h8 || port_we_o !== 1'b1 ||
          port_wdata_o !== 32'hA5A50001) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got req=%b addr=%h we=%b wdata=%h, required 1/8/1/a5a50001",
                 k, port_req_o, port_addr_o, port_we_o, port_wdata_o);
      end
      if (k < 3) begin
        total++;
        if (cmd_ready_o !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready[%0d]: got cmd_ready_o=%b, required 0", k, cmd_ready_o);
        end
      end
      if (k == 2) gnt_en = 1'b1;
    end
    wait_rsp(base + 1, "stall");
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    base = rsp_count;
    gnt_cyc_q.delete();
    rsp_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h40 + 32'(4 * i), 1'b0, '0);
      exp_q.push_back('{we: 1'b0, data: init_val(8'(16 + i))});
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    wait_rsp(base + 4, "b2b");
    ok = (gnt_cyc_q.size() == 4);
    for (int i = 1; i < gnt_cyc_q.size(); i++) if (gnt_cyc_q[i] != gnt_cyc_q[i-1] + 1) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_grants: got %0d grants, not all consecutive; required 4 consecutive",
               gnt_cyc_q.size());
    end
    ok = (rsp_cyc_q.size() == 4);
    for (int i = 1; i < rsp_cyc_q.size(); i++) if (rsp_cyc_q[i] != rsp_cyc_q[i-1] + 1) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_rsp: got %0d responses, not all consecutive; required 4 consecutive",
               rsp_cyc_q.size());
    end
  endtask

  task automatic test_limit();
    int base;
    base     = rsp_count;
    rsp_hold = 1'b1;
    credits  = 0;
    gnt_cyc_q.delete();
    send_cmd(32'h80, 1'b0, '0);
    exp_q.push_back('{we: 1'b0, data: init_val(8'h20)});
    send_cmd(32'h84, 1'b0, '0);
    exp_q.push_back('{we: 1'b0, data: init_val(8'h21)});
    @(negedge clk);
    cmd_addr_i = 32'h88;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (cmd_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL limit_ready[%0d]: got cmd_ready_o=%b, required 0", i, cmd_ready_o);
      end
      if (i > 0) begin
        total++;
        if (port_req_o !== 1'b0) begin
          bad++;
          $display("FAIL limit_req[%0d]: got port_req_o=%b, required 0", i, port_req_o);
        end
      end
    end
    total++;
    if (gnt_cyc_q.size() != 2) begin
      bad++;
      $display("FAIL limit_grants: got %0d grants, required 2", gnt_cyc_q.size());
    end
    credits = 1;
    @(negedge clk);
    #1;
    total++;
    if (cmd_ready_o !== 1'b1 || port_rvalid_i !== 1'b1) begin
      bad++;
      $display("FAIL limit_release: got cmd_ready_o=%b rvalid=%b, required 1/1",
               cmd_ready_o, port_rvalid_i);
    end
    exp_q.push_back('{we: 1'b0, data: init_val(8'h22)});
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    total++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h22) begin
      bad++;
      $display("FAIL limit_third: got req=%b addr=%h, required req=1 addr=00000022",
               port_req_o, port_addr_o);
    end
    rsp_hold = 1'b0;
    wait_rsp(base + 3, "limit");
    total++;
    if (gnt_cyc_q.size() != 3) begin
      bad++;
      $display("FAIL limit_total_grants: got %0d grants, required 3", gnt_cyc_q.size());
    end
  endtask

  task automatic test_write_read();
    int base;
    base = rsp_count;
    send_cmd(32'h100, 1'b1, 32'h1234);
    exp_q.push_back('{we: 1'b1, data: 32'h0});
    send_cmd(32'h100, 1'b0, '0);
    exp_q.push_back('{we: 1'b0, data: 32'h1234});
    @(negedge clk);
    cmd_valid_i = 1'b0;
    wait_rsp(base + 2, "wr_rd");
  endtask

  task automatic test_error();
    int base;
    base = rsp_count;
    spur = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL spur_rsp[%0d]: got rsp_valid_o=%b, required 0", i, rsp_valid_o);
      end
    end
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL spur_err: got err_o=%b, required 1", err_o);
    end
    // reset while a request is stalled
    gnt_en = 1'b0;
    send_cmd(32'h200, 1'b0, '0);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    total++;
    if (port_req_o !== 1'b1 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_pre_reset: got req=%b err=%b, required 1/1", port_req_o, err_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (port_req_o !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_midop: got req=%b err=%b, required 0/0", port_req_o, err_o);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    gnt_en = 1'b1;
    // an access granted before reset is answered only after reset release
    rsp_hold = 1'b1;
    credits  = 0;
    send_cmd(32'h204, 1'b0, '0);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rsp_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL stale_rsp[%0d]: got rsp_valid_o=%b, required 0", i, rsp_valid_o);
      end
    end
    total++;
    if (err_o !== 1'b1 || rsp_count != base) begin
      bad++;
      $display("FAIL stale_err: got err_o=%b extra_rsp=%0d, required err=1 extra_rsp=0",
               err_o, rsp_count - base);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    cyc           = 0;
    rsp_count     = 0;
    rvalid_cyc    = -10;
    gnt_en        = 1'b1;
    rsp_hold      = 1'b0;
    credits       = 0;
    spur          = 0;
    rst_n         = 1'b0;
    cmd_valid_i   = 1'b0;
    cmd_addr_i    = '0;
    cmd_we_i      = 1'b0;
    cmd_wdata_i   = '0;
    port_gnt_i    = 1'b0;
    port_rvalid_i = 1'b0;
    port_rdata_i  = '0;
    fork
      mem_model();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_read();
    test_stall();
    test_back_to_back();
    test_limit();
    test_write_read();
    test_error();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
